weather_sched: RTL and testbench

Scheduler and sequencer for the weather-prediction `decision_tree` datapath.
- Accepts daily weather samples (temp max/min, precipitation, wind, 4 bits each) over a valid/ready stream.
- Buffers them in a small FIFO and range-checks them.
- Issues one sample at a time to the decision tree, holding the operands stable for the tree's fixed latency.
- Captures the 5-bit class and returns it, tagged with a sequence number, on a valid/ready result stream.

---
 rtl/weather_sched.sv | 159 +++++++++++++++
 tb/tb_weather_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weather_sched.sv
// weather_sched: sample FIFO with range check, sequencer that feeds the
// fixed-latency decision tree one sample at a time, and a tagged result
// stream with valid/ready backpressure.
module weather_sched #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TREE_LAT   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [3:0] s_temp_max,
   input  logic [3:0] s_temp_min,
   input  logic [3:0] s_precip,
   input  logic [3:0] s_wind,
   output logic [3:0] tree_temp_max,
   output logic [3:0] tree_temp_min,
   output logic [3:0] tree_precip,
   output logic [3:0] tree_wind,
   input  logic [4:0] tree_class,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [4:0] m_class,
   output logic [7:0] m_tag,
   output logic [7:0] drop_cnt,
   output logic       busy
);

   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE   = 1;
   localparam logic [3:0]  WAIT_LOAD = 4'(TREE_LAT - 1);

   typedef struct packed {
      logic [3:0] temp_max;
      logic [3:0] temp_min;
      logic [3:0] precip;
      logic [3:0] wind;
      logic [7:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t      state_q, state_d;
   entry_t      mem_q [FIFO_DEPTH];
   entry_t      mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  tag_cnt_q, tag_cnt_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   entry_t      op_q, op_d;
   logic [4:0]  m_class_q, m_class_d;
   logic [7:0]  m_tag_q, m_tag_d;

   logic empty, full, accept, in_drop, push, pop;

   // Full when the pointers differ only in the wrap bit.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign accept  = s_valid && s_ready;
   assign in_drop = (s_temp_min > s_temp_max);
   assign push    = accept && !in_drop;

   // Sequencer: pop into operand registers, count down tree latency, hold result.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      op_d       = op_q;
      m_class_d  = m_class_q;
      m_tag_d    = m_tag_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) pop = 1'b1;
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               m_class_d = tree_class;
               m_tag_d   = op_q.tag;
               state_d   = ST_HOLD;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (m_ready) begin
               if (!empty) pop = 1'b1;
               else        state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         op_d       = mem_q[rd_ptr_q[AW-1:0]];
         wait_cnt_d = WAIT_LOAD;
         state_d    = ST_WAIT;
      end
   end

   // Input stage: FIFO write, read pointer advance, tag and drop counters.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      tag_cnt_d  = tag_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {s_temp_max, s_temp_min, s_precip, s_wind, tag_cnt_q};
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept) tag_cnt_d = tag_cnt_q + 8'd1;
      if (accept && in_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_cnt_q  <= '0;
         drop_cnt_q <= '0;
         wait_cnt_q <= '0;
         op_q       <= '0;
         m_class_q  <= '0;
         m_tag_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_cnt_q  <= tag_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         op_q       <= op_d;
         m_class_q  <= m_class_d;
         m_tag_q    <= m_tag_d;
      end
   end

   assign s_ready       = !full;
   assign tree_temp_max = op_q.temp_max;
   assign tree_temp_min = op_q.temp_min;
   assign tree_precip   = op_q.precip;
   assign tree_wind     = op_q.wind;
   assign m_valid       = (state_q == ST_HOLD);
   assign m_class       = m_class_q;
   assign m_tag         = m_tag_q;
   assign drop_cnt      = drop_cnt_q;
   assign busy          = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_weather_sched.sv
// Bench for weather_sched: scoreboard of expected {class, tag, operands}
// filled at each accepted sample, drained by a result monitor.
module tb_weather_sched;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TL    = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, s_ready;
   logic [3:0] s_temp_max, s_temp_min, s_precip, s_wind;
   logic [3:0] tree_temp_max, tree_temp_min, tree_precip, tree_wind;
   logic [4:0] tree_class;
   logic       m_valid, m_ready;
   logic [4:0] m_class;
   logic [7:0] m_tag, drop_cnt;
   logic       busy;

   always #5 clk = ~clk;

   weather_sched #(.FIFO_DEPTH(DEPTH), .TREE_LAT(TL)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_temp_max(s_temp_max), .s_temp_min(s_temp_min),
      .s_precip(s_precip), .s_wind(s_wind),
      .tree_temp_max(tree_temp_max), .tree_temp_min(tree_temp_min),
      .tree_precip(tree_precip), .tree_wind(tree_wind),
      .tree_class(tree_class),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_class(m_class), .m_tag(m_tag),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Tree model: arithmetic class, valid TL edges after operands change.
   function automatic logic [4:0] tree_fn(input logic [3:0] a, b, c, d);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b} + {1'b0, c} + {1'b0, d} + 5'd24;
      return s;
   endfunction

   logic [4:0] p0 = '0, p1 = '0;
   always @(posedge clk) begin
      p0 <= tree_fn(tree_temp_max, tree_temp_min, tree_precip, tree_wind);
      p1 <= p0;
   end
   assign tree_class = p1;

   typedef struct {
      logic [4:0] cls;
      logic [7:0] tag;
      logic [3:0] tmax, tmin, pr, wd;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] tag_m;
   logic [7:0] drop_m;
   int         rcnt = 0;
   logic [7:0] last_tag = '0;
   int         cyc = 0;
   int         prev_cyc = 0;
   bit         have_prev = 0;
   bit         tp_on = 0;
   exp_t       e;

   always @(posedge clk) cyc++;

   // Result monitor: compares every valid cycle, pops on handshake.
   always @(negedge clk) begin
      #1;
      if (!rst && m_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_valid", m_valid, 1'b0);
         end else begin
            e = sb_q[0];
            check_eq("m_class", m_class, e.cls);
            check_eq("m_tag", m_tag, e.tag);
            check_eq("op_tmax", tree_temp_max, e.tmax);
            check_eq("op_tmin", tree_temp_min, e.tmin);
            check_eq("op_wind", {tree_precip, tree_wind}, {e.pr, e.wd});
            if (m_ready) begin
               void'(sb_q.pop_front());
               rcnt++;
               last_tag = m_tag;
               if (tp_on && have_prev) check_eq("result_gap", cyc - prev_cyc, TL + 1);
               prev_cyc  = cyc;
               have_prev = 1;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      sb_q.delete();
      tag_m = '0;
      drop_m = '0;
      have_prev = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one sample from a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [3:0] tmax, tmin, pr, wd);
      int n = 0;
      s_valid = 1'b1;
      s_temp_max = tmax; s_temp_min = tmin; s_precip = pr; s_wind = wd;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check_eq("send_timeout", s_ready, 1'b1);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (tmin > tmax) begin
         if (drop_m != 8'hFF) drop_m++;
      end else begin
         sb_q.push_back('{tree_fn(tmax, tmin, pr, wd), tag_m, tmax, tmin, pr, wd});
      end
      tag_m++;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_sb_left", sb_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rc0, n;
      logic [3:0] a, b;
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
      s_temp_max = '0; s_temp_min = '0; s_precip = '0; s_wind = '0;
      tag_m = '0; drop_m = '0;
      repeat (2) @(negedge clk);

      // Reset values while rst is high.
      check_eq("rst_m_valid", m_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_s_ready", s_ready, 1'b1);
      check_eq("rst_drop", drop_cnt, 8'd0);
      check_eq("rst_tree", {tree_temp_max, tree_temp_min, tree_precip, tree_wind}, 16'h0);
      check_eq("rst_m_out", {m_class, m_tag}, 13'h0);
      rst = 1'b0;

      // 1: single sample latency and operand stability.
      m_ready = 1'b1;
      send(4'd9, 4'd3, 4'd2, 4'd5);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         #1;
         check_eq("lat_m_valid", m_valid, logic'(k == 4));
         if (k < 4) check_eq("lat_ops", {tree_temp_max, tree_temp_min, tree_precip, tree_wind}, 16'h9325);
         else       check_eq("lat_result", {m_class, m_tag}, {5'h0B, 8'd0});
      end
      wait_idle();

      // 2: dropped sample still consumes a tag.
      do_reset();
      rc0 = rcnt;
      send(4'd4, 4'd7, 4'd1, 4'd1);
      send(4'd8, 4'd2, 4'd6, 4'd3);
      wait_idle();
      check_eq("drop_one", drop_cnt, drop_m);
      check_eq("drop_results", rcnt - rc0, 1);
      check_eq("drop_tag", last_tag, 8'd1);

      // 3: backpressure fills the FIFO, then ordered release.
      do_reset();
      m_ready = 1'b0;
      rc0 = rcnt;
      for (int i = 0; i <= int'(DEPTH); i++) send(4'(8 + i), 4'(i), 4'(i), 4'(15 - i));
      check_eq("full_s_ready", s_ready, 1'b0);
      s_valid = 1'b1; s_temp_max = 4'd15; s_temp_min = 4'd1; s_precip = 4'd2; s_wind = 4'd3;
      repeat (6) begin
         @(negedge clk);
         check_eq("blocked_s_ready", s_ready, 1'b0);
      end
      check_eq("blocked_busy", busy, 1'b1);
      m_ready = 1'b1;
      send(4'd15, 4'd1, 4'd2, 4'd3);
      wait_idle();
      check_eq("bp_results", rcnt - rc0, DEPTH + 2);
      check_eq("bp_last_tag", last_tag, 8'(DEPTH + 1));

      // 4: sustained throughput, tag wrap, drop saturation.
      do_reset();
      m_ready = 1'b1;
      tp_on = 1;
      rc0 = rcnt;
      for (int i = 0; i < 300; i++) begin
         a = 4'($urandom_range(15, 0));
         b = 4'($urandom_range(a, 0));
         send(a, b, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      end
      wait_idle();
      tp_on = 0;
      check_eq("tp_results", rcnt - rc0, 300);
      check_eq("tp_wrap_tag", last_tag, 8'd43);
      for (int i = 0; i < 260; i++) begin
         a = 4'($urandom_range(14, 0));
         b = 4'($urandom_range(15, a + 1));
         send(a, b, 4'd0, 4'd0);
      end
      @(negedge clk);
      check_eq("drop_model_sat", drop_m, 8'hFF);
      check_eq("drop_sat", drop_cnt, drop_m);
      check_eq("drop_no_results", busy, 1'b0);

      // 5: reset while in WAIT with two buffered samples.
      do_reset();
      m_ready = 1'b0;
      send(4'd5, 4'd1, 4'd1, 4'd1);
      send(4'd6, 4'd2, 4'd2, 4'd2);
      send(4'd7, 4'd3, 4'd3, 4'd3);
      check_eq("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("arst_m_valid", m_valid, 1'b0);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_drop", drop_cnt, 8'd0);
      check_eq("arst_s_ready", s_ready, 1'b1);
      check_eq("arst_tree", {tree_temp_max, tree_temp_min, tree_precip, tree_wind}, 16'h0);
      sb_q.delete();
      tag_m = '0; drop_m = '0; have_prev = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      rc0 = rcnt;
      repeat (10) @(negedge clk);
      check_eq("no_ghost_result", rcnt - rc0, 0);
      send(4'd9, 4'd9, 4'd0, 4'd4);
      wait_idle();
      check_eq("post_rst_tag", last_tag, 8'd0);

      // 6: push and pop on the same edge with the FIFO half full.
      do_reset();
      m_ready = 1'b0;
      rc0 = rcnt;
      send(4'd3, 4'd0, 4'd1, 4'd2);
      send(4'd4, 4'd1, 4'd2, 4'd3);
      send(4'd5, 4'd2, 4'd3, 4'd4);
      n = 0;
      while (!m_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("pp_m_valid", m_valid, 1'b1);
      m_ready = 1'b1;
      send(4'd6, 4'd3, 4'd4, 4'd5);
      m_ready = 1'b0;
      send(4'd7, 4'd4, 4'd5, 4'd6);
      send(4'd8, 4'd5, 4'd6, 4'd7);
      check_eq("pp_full", s_ready, 1'b0);
      m_ready = 1'b1;
      wait_idle();
      check_eq("pp_results", rcnt - rc0, 6);
      check_eq("pp_last_tag", last_tag, 8'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
